// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared scan codes, sequence FSM states and key bit indices
package tetris_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_SPACE = 8'h29;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } seq_state_t;

    localparam int HB_LEFT   = 0;
    localparam int HB_RIGHT  = 1;
    localparam int HB_ROTATE = 2;
    localparam int HB_DOWN   = 3;

    typedef struct packed {
        logic       valid;
        logic       is_break;
        logic       is_ext;
        logic [7:0] code;
    } key_event_t;

endpackage

// File: rtl/ps2_seq_fsm.sv
// rtl/ps2_seq_fsm.sv - set-2 prefix FSM with sequence timeout, emits one registered key event
module ps2_seq_fsm
    import tetris_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] i_key_data,
    input  logic       i_key_valid,
    output key_event_t o_event
);

    seq_state_t             r_state;
    seq_state_t             w_next_state;
    logic       [CNT_W-1:0] r_cnt;
    key_event_t             r_event;
    key_event_t             w_event;
    logic                   w_timeout;

    assign w_timeout = (r_state != ST_IDLE) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_event <= '0;
        end else begin
            r_state <= w_next_state;
            r_event <= w_event;
            if (i_key_valid || w_timeout)
                r_cnt <= '0;
            else if (r_state != ST_IDLE)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // A byte arriving on the timeout cycle wins: it still completes the sequence.
    always_comb begin
        w_next_state = r_state;
        w_event      = '0;
        if (i_key_valid) begin
            w_event.code = i_key_data;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_key_data == SC_EXT)
                        w_next_state = ST_EXT;
                    else if (i_key_data == SC_BRK)
                        w_next_state = ST_BRK;
                    else
                        w_event.valid = 1'b1;
                end
                ST_EXT: begin
                    if (i_key_data == SC_BRK) begin
                        w_next_state = ST_EXT_BRK;
                    end else if (i_key_data != SC_EXT) begin
                        w_event.valid  = 1'b1;
                        w_event.is_ext = 1'b1;
                        w_next_state   = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    w_event.valid    = 1'b1;
                    w_event.is_break = 1'b1;
                    w_next_state     = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    w_event.valid    = 1'b1;
                    w_event.is_break = 1'b1;
                    w_event.is_ext   = 1'b1;
                    w_next_state     = ST_IDLE;
                end
                default: w_next_state = ST_IDLE;
            endcase
        end else if (w_timeout) begin
            w_next_state = ST_IDLE;
        end
    end

    assign o_event = r_event;

endmodule

// File: rtl/ps2_move_decoder.sv
// rtl/ps2_move_decoder.sv - maps key events to held/pending moves and issues them on the game tick
module ps2_move_decoder
    import tetris_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] key_data,
    input  logic       key_valid,
    input  logic       tick_en,
    output logic       left_true,
    output logic       right_true,
    output logic       rotate_true,
    output logic       speed_true,
    output logic [3:0] held
);

    key_event_t w_event;
    logic [3:0] r_held;
    logic [2:0] r_pend;
    logic       r_left;
    logic       r_right;
    logic       r_rotate;
    logic       r_speed;
    logic       w_hit;
    logic [1:0] w_idx;
    logic [3:0] w_mask;
    logic [3:0] w_held_next;
    logic [2:0] w_pend_set;

    ps2_seq_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_seq (
        .clock       (clock),
        .resetn      (resetn),
        .i_key_data  (key_data),
        .i_key_valid (key_valid),
        .o_event     (w_event)
    );

    // Keypad arrows (non-extended) deliberately fall through unmapped.
    always_comb begin
        w_hit = 1'b0;
        w_idx = 2'd0;
        if (w_event.is_ext) begin
            unique case (w_event.code)
                SC_LEFT:  begin w_hit = 1'b1; w_idx = 2'(HB_LEFT);   end
                SC_RIGHT: begin w_hit = 1'b1; w_idx = 2'(HB_RIGHT);  end
                SC_DOWN:  begin w_hit = 1'b1; w_idx = 2'(HB_DOWN);   end
                SC_UP:    begin w_hit = 1'b1; w_idx = 2'(HB_ROTATE); end
                default:  ;
            endcase
        end else if (w_event.code == SC_SPACE) begin
            w_hit = 1'b1;
            w_idx = 2'(HB_ROTATE);
        end
    end

    always_comb begin
        w_mask      = (w_event.valid && w_hit) ? (4'b0001 << w_idx) : 4'b0000;
        w_held_next = r_held;
        w_pend_set  = 3'b000;
        if (w_event.is_break) begin
            w_held_next = r_held & ~w_mask;
        end else begin
            w_held_next = r_held | w_mask;
            w_pend_set  = w_mask[2:0] & ~r_held[2:0];
        end
    end

    // A new press on the tick cycle is merged after the clear so it is not lost.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_held   <= '0;
            r_pend   <= '0;
            r_left   <= 1'b0;
            r_right  <= 1'b0;
            r_rotate <= 1'b0;
            r_speed  <= 1'b0;
        end else begin
            r_held  <= w_held_next;
            r_speed <= r_held[HB_DOWN];
            if (tick_en) begin
                r_left   <= r_pend[HB_LEFT] & ~r_pend[HB_RIGHT];
                r_right  <= r_pend[HB_RIGHT] & ~r_pend[HB_LEFT];
                r_rotate <= r_pend[HB_ROTATE];
                r_pend   <= w_pend_set;
            end else begin
                r_pend <= r_pend | w_pend_set;
            end
        end
    end

    assign left_true   = r_left;
    assign right_true  = r_right;
    assign rotate_true = r_rotate;
    assign speed_true  = r_speed;
    assign held        = r_held;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// tb/tb_ps2_move_decoder.sv - directed self-checking bench for ps2_move_decoder
module tb_ps2_move_decoder;

    localparam int T = 40;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] key_data = 8'h00;
    logic       key_valid = 1'b0;
    logic       tick_en = 1'b0;
    logic       left_true;
    logic       right_true;
    logic       rotate_true;
    logic       speed_true;
    logic [3:0] held;

    int checks = 0;
    int failures = 0;

    ps2_move_decoder #(
        .TIMEOUT_CYCLES (T),
        .CNT_W          (8)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .key_data    (key_data),
        .key_valid   (key_valid),
        .tick_en     (tick_en),
        .left_true   (left_true),
        .right_true  (right_true),
        .rotate_true (rotate_true),
        .speed_true  (speed_true),
        .held        (held)
    );

    always #10 clock = ~clock;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clock);
        key_data  = b;
        key_valid = 1'b1;
        @(negedge clock);
        key_valid = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    task automatic tick();
        repeat (3) @(negedge clock);
        tick_en = 1'b1;
        @(negedge clock);
        tick_en = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clock);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check_eq("reset_outs", {left_true, right_true, rotate_true, speed_true}, 4'b0000);
        check_eq("reset_held", held, 4'b0000);

        // short press then release still yields one move
        send_byte(8'hE0, 0); send_byte(8'h6B, 0); settle();
        check_eq("left_held", held, 4'b0001);
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h6B, 0); settle();
        check_eq("left_released", held, 4'b0000);
        tick();
        check_eq("left_tick1", 4'(left_true), 4'd1);
        tick();
        check_eq("left_tick2", 4'(left_true), 4'd0);

        // typematic repeats produce a single move
        for (int i = 0; i < 5; i++) begin
            send_byte(8'hE0, 0); send_byte(8'h74, 2);
        end
        settle();
        check_eq("right_rep_held", held, 4'b0010);
        tick();
        check_eq("right_tick1", 4'(right_true), 4'd1);
        tick();
        check_eq("right_tick2", 4'(right_true), 4'd0);
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h74, 0);

        // left and right pending together cancel
        send_byte(8'hE0, 0); send_byte(8'h6B, 0);
        send_byte(8'hE0, 0); send_byte(8'h74, 0); settle();
        tick();
        check_eq("both_cancel", {2'b00, left_true, right_true}, 4'b0000);
        check_eq("both_held", held, 4'b0011);
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h6B, 0);
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h74, 0);

        // space rotates; down drives speed without a tick
        send_byte(8'h29, 0); settle();
        check_eq("space_held", held, 4'b0100);
        tick();
        check_eq("rotate_tick", 4'(rotate_true), 4'd1);
        send_byte(8'hF0, 0); send_byte(8'h29, 0);
        send_byte(8'hE0, 0); send_byte(8'h72, 0);
        check_eq("speed_c1", 4'(speed_true), 4'd0);
        @(negedge clock);
        check_eq("speed_c1_held", held, 4'b1000);
        check_eq("speed_c2pre", 4'(speed_true), 4'd0);
        @(negedge clock);
        check_eq("speed_c2", 4'(speed_true), 4'd1);
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h72, 0); settle();
        check_eq("speed_off", 4'(speed_true), 4'd0);
        tick();
        check_eq("rotate_clear", 4'(rotate_true), 4'd0);

        // prefix timeout: full gap abandons E0, shorter gap keeps it
        send_byte(8'hE0, T); send_byte(8'h6B, 0); settle();
        check_eq("timeout_held", held, 4'b0000);
        tick();
        check_eq("timeout_left", 4'(left_true), 4'd0);
        send_byte(8'hE0, T - 2); send_byte(8'h6B, 0); settle();
        check_eq("no_timeout_held", held, 4'b0001);
        tick();
        check_eq("no_timeout_left", 4'(left_true), 4'd1);
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h6B, 0);

        // reset mid-sequence discards the prefix and clears outputs
        send_byte(8'hE0, 0);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        check_eq("rst_mid_outs", {left_true, right_true, rotate_true, speed_true}, 4'b0000);
        send_byte(8'h6B, 0); settle();
        check_eq("rst_mid_held", held, 4'b0000);
        tick();
        check_eq("rst_mid_left", 4'(left_true), 4'd0);

        // decode landing on the tick cycle is issued on the following tick
        send_byte(8'hE0, 0);
        key_data  = 8'h6B;
        key_valid = 1'b1;
        @(negedge clock);
        key_valid = 1'b0;
        tick_en   = 1'b1;
        @(negedge clock);
        tick_en   = 1'b0;
        check_eq("coinc_tick1", 4'(left_true), 4'd0);
        tick();
        check_eq("coinc_tick2", 4'(left_true), 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_move_decoder.md
Name: ps2_move_decoder

Overview:
- Converts the raw PS/2 byte stream from the keyboard interface into game-move requests for the Tetris field logic.
- Decodes set-2 make/break/extended sequences and tracks the held state of four control keys.
- Latches one move request per physical press and presents the requests aligned to the game tick.
- Sits directly downstream of the PS/2 interface and replaces the key-stabilise and key-process stages that feed the field.

Parameters:
- TIMEOUT_CYCLES, 1000000: clocks allowed between a prefix byte (E0/F0) and its following byte before the decoder abandons the sequence (20 ms at 50 MHz).
- CNT_W, 20: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, 50 MHz.
- resetn  in  1  synchronous, active-low reset.
- key_data  in  8  PS/2 scan byte; valid only while key_valid=1.
- key_valid  in  1  single-cycle strobe, one per received byte.
- tick_en  in  1  single-cycle game-tick enable (10 Hz rate).
- left_true  out  1  move-left request; held for one full tick interval.
- right_true  out  1  move-right request; held for one full tick interval.
- rotate_true  out  1  rotate request; held for one full tick interval.
- speed_true  out  1  level; 1 while the down key is held.
- held  out  4  debug; {down, rotate, right, left} held bits.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - all outputs, pending bits, held bits and counter go to 0.
  - FSM goes to IDLE.
  - A reset mid-sequence discards any partial sequence.
- Key map (set 2):
  - E0 6B = left; E0 74 = right; E0 72 = down.
  - E0 75 (up arrow) or non-extended 29 (space) = rotate.
  - Non-extended 6B/74/72/75 (keypad) are ignored.
  - All other codes are ignored but still consume the FSM sequence.
- FSM states: IDLE, EXT, BRK, EXT_BRK. All transitions occur only on key_valid.
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - Other byte -> make event (non-extended); stay in IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> stay in EXT.
    - Other byte -> extended make event; go to IDLE.
  - BRK: any byte -> non-extended break event; go to IDLE.
  - EXT_BRK: any byte -> extended break event; go to IDLE.
- Timeout:
  - The counter clears on every key_valid and increments each cycle while the FSM is not in IDLE.
  - When it reaches TIMEOUT_CYCLES-1 the FSM returns to IDLE with no event and the counter clears.
- Make event for a mapped key:
  - If its held bit is 0: set held and set the pending bit (left, right and rotate only).
  - If its held bit is already 1 (typematic repeat): no effect.
- Break event for a mapped key: clear held. Pending bits are not cleared, so a press shorter than a tick still produces a move.
- Decode timing: the event takes effect in the cycle after key_valid (one-cycle registered decode).
- On tick_en:
  - left_true <= pend_left & ~pend_right.
  - right_true <= pend_right & ~pend_left. If both are pending, both are cancelled.
  - rotate_true <= pend_rotate.
  - All pending bits clear.
  - Outputs hold their value until the next tick_en.
- Simultaneous decode and tick in the same cycle: the event lands in pending after the clear and is issued on the next tick. It is not lost.
- speed_true = registered copy of the held down bit. It updates one cycle after the decode and is independent of tick_en.
- held output mirrors the held register.

Decomposition:
- Shared package (tetris_pkg) holds:
  - scan-code constants: SC_EXT=E0, SC_BRK=F0, SC_LEFT=6B, SC_RIGHT=74, SC_UP=75, SC_DOWN=72, SC_SPACE=29.
  - FSM state encoding (2 bits).
  - held/pending bit indices.
- One sub-module: ps2_seq_fsm. It contains the prefix FSM and timeout counter and emits {event_valid, is_break, is_ext, code}.
- The parent contains the key map, held/pending registers and tick alignment.

Test Plan:
- Bytes E0 6B, then E0 F0 6B, then tick_en -> left_true=1 until the next tick; at the following tick left_true=0.
- Bytes E0 74 repeated 5 times (typematic), no break, then tick -> right_true=1 for one interval only. A second tick -> 0.
- E0 6B and E0 74 both before one tick -> left_true=0 and right_true=0 after the tick; held=4'b0011.
- Byte 29 -> rotate_true=1 after the tick. Bytes E0 72 -> speed_true=1 two cycles after key_valid with no tick needed. E0 F0 72 -> speed_true=0.
- Byte E0, then no byte for TIMEOUT_CYCLES, then 6B -> treated as non-extended (keypad), so no left request. Repeat with the gap at TIMEOUT_CYCLES-2 -> left request issued.
- Byte E0, then resetn=0 for one cycle, then 6B -> no request, all outputs 0. A key_valid decode landing in the same cycle as tick_en -> the request is issued on the next tick.
